// File: rtl/tmr_clk_presel.sv
//-----------------------------------------------------------------------------
// tmr_clk_presel
//
// Clock-source and prescaler stage for the 8-bit timer counter. It selects
// one of four PCLK divisions (/2, /4, /8, /16) or a synchronized external
// pin. It produces a glitch-free, PCLK-registered square wave (clk_in) and a
// one-cycle strobe (tick) in the cycle clk_in goes 0->1.
//
// Optional feature macro: TMR_EXT_EDGE_SEL_EN
//   defined   : TCR[3] inverts the synchronized external input, so falling
//               ext_clk edges count. TCR[3] is part of the select, so
//               changing it forces a SWITCH/ARM pass.
//   undefined : TCR[3] is ignored and only rising ext_clk edges count.
//
// Parameters:
//   SYNC_STAGES  flops synchronizing ext_clk (>= 2)
//   DIV_W        prescaler counter width; bit s gives division 2^(s+1) (>= 4)
//
// Ports:
//   PCLK      in   system/APB clock, the only clock
//   PRESET    in   asynchronous active-high reset
//   TCR[7:0]  in   timer control: [7] Load, [4] EN, [3] EDG, [2] EXT, [1:0] CKS
//   ext_clk   in   external count source, asynchronous to PCLK
//   clk_in    out  registered count clock to the timer counter
//   tick      out  one-PCLK pulse coincident with the clk_in rising edge
//   ps_state  out  FSM state for debug: OFF=0, RUN=1, SWITCH=2, ARM=3
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tmr_clk_presel #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [7:0] TCR,
  input  logic       ext_clk,
  output logic       clk_in,
  output logic       tick,
  output logic [1:0] ps_state
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2,
    ST_ARM    = 2'd3
  } state_e;

`ifdef TMR_EXT_EDGE_SEL_EN
  localparam int SEL_W = 4;
`else
  localparam int SEL_W = 3;
`endif

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       sel_q, sel_d, sel;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   clk_in_q, clk_in_d;
  logic                   tick_q, tick_d;
  logic                   ext_s, ext_eff;
  logic                   tcr_en, tcr_load;
  logic                   unused_tcr;

  assign tcr_en   = TCR[4];
  assign tcr_load = TCR[7];
  assign ext_s    = sync_q[SYNC_STAGES-1];

`ifdef TMR_EXT_EDGE_SEL_EN
  assign sel        = TCR[3:0];
  // Inversion uses the registered select so it only changes across SWITCH/ARM.
  assign ext_eff    = ext_s ^ sel_q[3];
  assign unused_tcr = ^TCR[6:5];
`else
  assign sel        = TCR[2:0];
  assign ext_eff    = ext_s;
  assign unused_tcr = ^{TCR[6:5], TCR[3]};
`endif

  // ext_clk synchronizer; only ext_s (the last stage) is ever looked at.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state is always assigned with <= so every flop
      // samples the pre-edge value of its neighbours, as real flops do.
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_clk};
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      sel_q    <= '0;
      clk_in_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      clk_in_q <= clk_in_d;
      tick_q   <= tick_d;
    end
  end

  // Edge priority: EN=0 > Load=1 > select change > normal run. clk_in_d is
  // only ever non-zero when the FSM stays in RUN, so clk_in can never rise
  // on a state-transition edge.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a signal unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = '0;
    sel_d    = sel_q;
    clk_in_d = 1'b0;

    if (!tcr_en) begin
      state_d = ST_OFF;
    end else if (state_q == ST_OFF) begin
      if (!tcr_load) begin
        sel_d   = sel;
        state_d = sel[2] ? ST_ARM : ST_RUN;
      end
    end else if (tcr_load) begin
      state_d = ST_SWITCH;
    end else if (state_q == ST_SWITCH) begin
      // Exit after one cycle with whatever select is current right now.
      sel_d   = sel;
      state_d = sel[2] ? ST_ARM : ST_RUN;
    end else if (sel != sel_q) begin
      state_d = ST_SWITCH;
    end else if (state_q == ST_ARM) begin
      // Wait for a low level so the first RUN edge cannot be a false rise.
      if (!ext_eff) begin
        state_d = ST_RUN;
      end
    end else begin
      if (sel_q[2]) begin
        clk_in_d = ext_eff;
      end else begin
        clk_in_d = cnt_q[sel_q[1:0]];
        cnt_d    = cnt_q + DIV_W'(1);
      end
    end

    tick_d = clk_in_d & ~clk_in_q;
  end

  assign clk_in   = clk_in_q;
  assign tick     = tick_q;
  assign ps_state = state_q;

endmodule
